// File: rtl/aw_write_arbiter.sv
// Two-master AW arbiter/sequencer: holds the grant until the matching W burst ends (WLAST).
// Define AW_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
module aw_write_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SLV_SEL_LSB = ADDR_W - 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              M0_AWVALID,
    input  logic [ADDR_W-1:0] M0_AWADDR,
    input  logic              M1_AWVALID,
    input  logic [ADDR_W-1:0] M1_AWADDR,
    input  logic              S_AWREADY,
    input  logic              S_WVALID,
    input  logic              S_WREADY,
    input  logic              S_WLAST,
    output logic              M0_AWREADY,
    output logic              M1_AWREADY,
    output logic              Master_Sel,
    output logic [1:0]        Selected_Slave,
    output logic              sel_valid,
    output logic              w_busy,
    output logic              rr_ptr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WBURST = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       master_sel_q;
    logic [1:0] slave_q;
    logic       w_done_early_q;
    logic       rr_ptr_q;

    logic       any_req;
    logic       winner;
    logic [1:0] winner_slave;
    logic       granted_valid;
    logic       aw_hs;
    logic       wlast_hs;
    logic       release_grant;
    logic       unused_addr_bits;

    assign any_req       = M0_AWVALID | M1_AWVALID;
    // Tie goes to the pointer; a lone requester wins outright.
    assign winner        = (M0_AWVALID & M1_AWVALID) ? rr_ptr_q : M1_AWVALID;
    assign winner_slave  = winner ? M1_AWADDR[SLV_SEL_LSB +: 2] : M0_AWADDR[SLV_SEL_LSB +: 2];
    assign granted_valid = master_sel_q ? M1_AWVALID : M0_AWVALID;
    assign aw_hs         = (state_q == GRANT) & granted_valid & S_AWREADY;
    assign wlast_hs      = S_WVALID & S_WREADY & S_WLAST;
    assign release_grant = (state_q != IDLE) & (state_d == IDLE);
    assign unused_addr_bits = ^{M0_AWADDR, M1_AWADDR};

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A W burst that already finished (or finishes now) skips WBURST.
                if (aw_hs) begin
                    state_d = (wlast_hs | w_done_early_q) ? IDLE : WBURST;
                end
            end
            WBURST: begin
                if (wlast_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant context captured at GRANT entry, held until IDLE re-entry
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            master_sel_q   <= 1'b0;
            slave_q        <= 2'd0;
            w_done_early_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && any_req) begin
                master_sel_q <= winner;
                slave_q      <= winner_slave;
            end
            if (state_d == IDLE) begin
                w_done_early_q <= 1'b0;
            end else if ((state_q == GRANT) && wlast_hs && !aw_hs) begin
                w_done_early_q <= 1'b1;
            end
        end
    end

`ifdef AW_ARB_FIXED_PRIO_EN
    assign rr_ptr_q = 1'b0;
`else
    // Priority passes to the other master whenever a grant completes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rr_ptr_q <= 1'b0;
        end else if (release_grant) begin
            rr_ptr_q <= ~master_sel_q;
        end
    end
`endif

    // Output decode from registered state
    always_comb begin
        M0_AWREADY     = 1'b0;
        M1_AWREADY     = 1'b0;
        sel_valid      = (state_q == GRANT);
        w_busy         = (state_q == WBURST);
        Master_Sel     = master_sel_q;
        Selected_Slave = slave_q;
        rr_ptr         = rr_ptr_q;
        if (state_q == GRANT) begin
            M0_AWREADY = S_AWREADY & ~master_sel_q;
            M1_AWREADY = S_AWREADY &  master_sel_q;
        end
    end

endmodule

// File: tb/tb_aw_write_arbiter.sv
// Directed self-checking bench for aw_write_arbiter (default and AW_ARB_FIXED_PRIO_EN builds).
module tb_aw_write_arbiter;

`ifdef AW_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        M0_AWVALID, M1_AWVALID;
    logic [31:0] M0_AWADDR, M1_AWADDR;
    logic        S_AWREADY, S_WVALID, S_WREADY, S_WLAST;
    logic        M0_AWREADY, M1_AWREADY, Master_Sel, sel_valid, w_busy, rr_ptr;
    logic [1:0]  Selected_Slave;

    int n_checks = 0;
    int n_fail   = 0;

    aw_write_arbiter #(.ADDR_W(32), .SLV_SEL_LSB(30)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M0_AWVALID(M0_AWVALID), .M0_AWADDR(M0_AWADDR),
        .M1_AWVALID(M1_AWVALID), .M1_AWADDR(M1_AWADDR),
        .S_AWREADY(S_AWREADY), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WLAST(S_WLAST),
        .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY),
        .Master_Sel(Master_Sel), .Selected_Slave(Selected_Slave),
        .sel_valid(sel_valid), .w_busy(w_busy), .rr_ptr(rr_ptr)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_w(input logic v, input logic last);
        S_WVALID = v;
        S_WREADY = v;
        S_WLAST  = last;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1;
        M0_AWVALID = 1'b0; M1_AWVALID = 1'b0;
        M0_AWADDR = 32'h0; M1_AWADDR = 32'h0;
        S_AWREADY = 1'b0;
        set_w(1'b0, 1'b0);
        tick();
        #1;
        chk1("rst_sel_valid", sel_valid, 1'b0);
        chk1("rst_w_busy", w_busy, 1'b0);
        chk1("rst_master_sel", Master_Sel, 1'b0);
        chk2("rst_slave", Selected_Slave, 2'd0);
        chk1("rst_rr_ptr", rr_ptr, 1'b0);
        chk1("rst_m0_awready", M0_AWREADY, 1'b0);
        chk1("rst_m1_awready", M1_AWREADY, 1'b0);
        tick();
        ARESET = 1'b0;

        // Single request from M0, four-beat burst
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h8000_0000; S_AWREADY = 1'b1;
        tick();
        chk1("t1_sel_valid", sel_valid, 1'b1);
        chk1("t1_master_sel", Master_Sel, 1'b0);
        chk2("t1_slave", Selected_Slave, 2'd2);
        chk1("t1_m0_awready", M0_AWREADY, 1'b1);
        chk1("t1_m1_awready", M1_AWREADY, 1'b0);
        tick();
        M0_AWVALID = 1'b0;
        chk1("t1_w_busy", w_busy, 1'b1);
        chk1("t1_m0_awready_wburst", M0_AWREADY, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_w(1'b1, b == 3);
            tick();
            if (b < 3) chk1("t1_w_busy_beat", w_busy, 1'b1);
        end
        set_w(1'b0, 1'b0);
        chk1("t1_idle_w_busy", w_busy, 1'b0);
        chk1("t1_idle_sel_valid", sel_valid, 1'b0);
        chk1("t1_rr_ptr", rr_ptr, FIXED ? 1'b0 : 1'b1);

        // Simultaneous requests after reset: M0 first, then M1 after one idle cycle
        do_reset();
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h4000_0000;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'hC000_0000;
        S_AWREADY = 1'b1;
        tick();
        chk1("t2_master_sel_first", Master_Sel, 1'b0);
        chk2("t2_slave_first", Selected_Slave, 2'd1);
        chk1("t2_m0_awready", M0_AWREADY, 1'b1);
        chk1("t2_m1_awready", M1_AWREADY, 1'b0);
        tick();
        M0_AWVALID = 1'b0;
        chk1("t2_w_busy", w_busy, 1'b1);
        set_w(1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0);
        chk1("t2_bubble_sel_valid", sel_valid, 1'b0);
        chk1("t2_bubble_w_busy", w_busy, 1'b0);
        tick();
        chk1("t2_sel_valid_second", sel_valid, 1'b1);
        chk1("t2_master_sel_second", Master_Sel, 1'b1);
        chk2("t2_slave_second", Selected_Slave, 2'd3);
        chk1("t2_m1_awready_second", M1_AWREADY, 1'b1);
        chk1("t2_m0_awready_second", M0_AWREADY, 1'b0);
        tick();
        M1_AWVALID = 1'b0;
        set_w(1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0);
        chk1("t2_rr_ptr_after_m1", rr_ptr, 1'b0);

        // Back-to-back fairness, both masters continuously valid
        M0_AWVALID = 1'b1; M0_AWADDR = 32'h0000_0000;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t3_sel_valid", sel_valid, 1'b1);
            chk1("t3_grant_order", Master_Sel, FIXED ? 1'b0 : 1'((i % 2) == 1));
            tick();
            chk1("t3_w_busy", w_busy, 1'b1);
            set_w(1'b1, 1'b1);
            tick();
            set_w(1'b0, 1'b0);
        end
        M0_AWVALID = 1'b0; M1_AWVALID = 1'b0;
        tick();

        // W burst completes before the AW handshake
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h4000_0000; S_AWREADY = 1'b0;
        tick();
        chk1("t4_sel_valid", sel_valid, 1'b1);
        chk1("t4_master_sel", Master_Sel, 1'b1);
        chk1("t4_m1_awready_low", M1_AWREADY, 1'b0);
        set_w(1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0);
        chk1("t4_still_grant", sel_valid, 1'b1);
        chk1("t4_w_busy_grant", w_busy, 1'b0);
        S_AWREADY = 1'b1;
        #1;
        chk1("t4_m1_awready_high", M1_AWREADY, 1'b1);
        tick();
        M1_AWVALID = 1'b0;
        chk1("t4_idle_sel_valid", sel_valid, 1'b0);
        chk1("t4_idle_w_busy", w_busy, 1'b0);
        chk1("t4_rr_ptr", rr_ptr, 1'b0);

        // Backpressure with both valid; grant context must hold
        M0_AWVALID = 1'b1; M0_AWADDR = 32'hC000_0000;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h0000_0000;
        S_AWREADY = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("t5_m0_awready", M0_AWREADY, 1'b0);
            chk1("t5_m1_awready", M1_AWREADY, 1'b0);
            chk1("t5_master_sel", Master_Sel, 1'b0);
            chk2("t5_slave", Selected_Slave, 2'd3);
            chk1("t5_sel_valid", sel_valid, 1'b1);
            M0_AWADDR = 32'h4000_0000;
            M0_AWVALID = (i != 2);
            tick();
        end
        M0_AWVALID = 1'b1;
        S_AWREADY = 1'b1;
        #1;
        chk1("t5_m0_awready_release", M0_AWREADY, 1'b1);
        chk1("t5_m1_awready_release", M1_AWREADY, 1'b0);
        tick();
        M0_AWVALID = 1'b0;
        chk1("t5_w_busy", w_busy, 1'b1);
        set_w(1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0);
        chk1("t5_rr_ptr", rr_ptr, FIXED ? 1'b0 : 1'b1);

        // Reset in the middle of a burst
        M1_AWADDR = 32'h8000_0000;
        tick();
        chk1("t6_master_sel", Master_Sel, 1'b1);
        tick();
        M1_AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            set_w(1'b1, 1'b0);
            tick();
        end
        chk1("t6_w_busy_pre", w_busy, 1'b1);
        ARESET = 1'b1;
        #1;
        chk1("t6_rst_w_busy", w_busy, 1'b0);
        chk1("t6_rst_sel_valid", sel_valid, 1'b0);
        chk1("t6_rst_rr_ptr", rr_ptr, 1'b0);
        chk1("t6_rst_master_sel", Master_Sel, 1'b0);
        chk2("t6_rst_slave", Selected_Slave, 2'd0);
        set_w(1'b0, 1'b0);
        tick();
        ARESET = 1'b0;
        M1_AWVALID = 1'b1; M1_AWADDR = 32'h4000_0000;
        tick();
        chk1("t6_regrant_sel_valid", sel_valid, 1'b1);
        chk1("t6_regrant_master_sel", Master_Sel, 1'b1);
        chk2("t6_regrant_slave", Selected_Slave, 2'd1);
        chk1("t6_regrant_m1_awready", M1_AWREADY, 1'b1);
        M1_AWVALID = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
